// File: rtl/rggen_bus_responder_pkg.sv
// rtl/rggen_bus_responder_pkg.sv - shared types and constants for the external register bus responder
package rggen_bus_responder_pkg;

  typedef enum logic [1:0] {
    STATUS_OKAY   = 2'b00,
    STATUS_EXOKAY = 2'b01,
    STATUS_SLVERR = 2'b10,
    STATUS_DECERR = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WAIT    = 2'b01,
    ST_RESPOND = 2'b10
  } state_e;

  localparam int WAIT_COUNTER_WIDTH = 4;

endpackage

// File: rtl/rggen_bus_responder_storage.sv
// rtl/rggen_bus_responder_storage.sv - word array with byte-strobe write port and combinational read port
module rggen_bus_responder_storage
  import rggen_bus_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 16,
  parameter int IDX_W      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we_i,
  input  logic [IDX_W-1:0]        windex_i,
  input  logic [DATA_WIDTH/8-1:0] strobe_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [IDX_W-1:0]        rindex_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int w = 0; w < WORDS; w++) begin
        mem_q[w] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (strobe_i[b]) begin
          mem_q[windex_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[rindex_i];

endmodule

// File: rtl/rggen_bus_responder.sv
// rtl/rggen_bus_responder.sv - external register bus target with wait states and a strobed register file
// Define RGGEN_BUS_RESPONDER_RANGE_CHECK_EN to answer DECERR for word indices >= WORDS instead of aliasing.
module rggen_bus_responder
  import rggen_bus_responder_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int WORDS         = 16,
  parameter int WAIT_CYCLES   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  input  logic                     i_write,
  input  logic                     i_read,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH/8-1:0]  i_strobe,
  input  logic [DATA_WIDTH-1:0]    i_write_data,
  output logic                     o_ready,
  output logic [DATA_WIDTH-1:0]    o_read_data,
  output logic [1:0]               o_status,
  output logic                     o_busy
);

  localparam int STROBE_WIDTH = DATA_WIDTH / 8;
  localparam int OFFSET_BITS  = $clog2(STROBE_WIDTH);
  localparam int INDEX_WIDTH  = ADDRESS_WIDTH - OFFSET_BITS;
  localparam int IDX_W        = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e                        state_q;
  logic [WAIT_COUNTER_WIDTH-1:0] count_q;
  logic                          write_q;
  logic                          read_q;
  logic [INDEX_WIDTH-1:0]        index_q;
  logic [STROBE_WIDTH-1:0]       strobe_q;
  logic [DATA_WIDTH-1:0]         data_q;
  logic                          commit_q;
  logic                          ready_q;
  logic                          busy_q;
  logic [DATA_WIDTH-1:0]         read_data_q;
  status_e                       status_q;

  logic                   cur_write;
  logic                   cur_read;
  logic [INDEX_WIDTH-1:0] cur_index;
  logic                   in_range;
  logic                   enter_respond_d;
  status_e                resp_status_d;
  logic [DATA_WIDTH-1:0]  resp_data_d;
  logic                   resp_commit_d;
  logic [DATA_WIDTH-1:0]  mem_rdata;

  function automatic logic [IDX_W-1:0] word_sel(input logic [INDEX_WIDTH-1:0] idx);
    if (WORDS == 1) return '0;
    return idx[IDX_W-1:0];
  endfunction

  // With no wait states the response is formed on the capture edge, so the live request is used.
  assign cur_write = (state_q == ST_IDLE) ? i_write : write_q;
  assign cur_read  = (state_q == ST_IDLE) ? i_read  : read_q;
  assign cur_index = (state_q == ST_IDLE) ? i_address[ADDRESS_WIDTH-1:OFFSET_BITS] : index_q;

`ifdef RGGEN_BUS_RESPONDER_RANGE_CHECK_EN
  assign in_range = ({1'b0, cur_index} < (INDEX_WIDTH+1)'(WORDS));
`else
  assign in_range = 1'b1;
`endif

  assign enter_respond_d = ((state_q == ST_IDLE) && i_valid && (WAIT_CYCLES == 0)) ||
                           ((state_q == ST_WAIT) && (count_q == '0));

  always_comb begin
    resp_status_d = STATUS_OKAY;
    resp_data_d   = '0;
    resp_commit_d = 1'b0;
    if (cur_write == cur_read) begin
      resp_status_d = STATUS_SLVERR;
    end else if (!in_range) begin
      resp_status_d = STATUS_DECERR;
    end else if (cur_write) begin
      resp_commit_d = 1'b1;
    end else begin
      resp_data_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      index_q     <= '0;
      strobe_q    <= '0;
      data_q      <= '0;
      commit_q    <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      read_data_q <= '0;
      status_q    <= STATUS_OKAY;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            write_q  <= i_write;
            read_q   <= i_read;
            index_q  <= i_address[ADDRESS_WIDTH-1:OFFSET_BITS];
            strobe_q <= i_strobe;
            data_q   <= i_write_data;
            busy_q   <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_q <= ST_RESPOND;
            end else begin
              state_q <= ST_WAIT;
              count_q <= WAIT_COUNTER_WIDTH'(WAIT_CYCLES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (count_q == '0) begin
            state_q <= ST_RESPOND;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        ST_RESPOND: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          commit_q    <= 1'b0;
          read_data_q <= '0;
          status_q    <= STATUS_OKAY;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (enter_respond_d) begin
        ready_q     <= 1'b1;
        status_q    <= resp_status_d;
        read_data_q <= resp_data_d;
        commit_q    <= resp_commit_d;
      end
    end
  end

  // The write lands on the edge that closes the RESPOND cycle.
  rggen_bus_responder_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORDS      (WORDS),
    .IDX_W      (IDX_W)
  ) u_storage (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     ((state_q == ST_RESPOND) && commit_q),
    .windex_i (word_sel(index_q)),
    .strobe_i (strobe_q),
    .wdata_i  (data_q),
    .rindex_i (word_sel(cur_index)),
    .rdata_o  (mem_rdata)
  );

  assign o_ready     = ready_q;
  assign o_read_data = read_data_q;
  assign o_status    = status_q;
  assign o_busy      = busy_q;

  logic unused_bits;
  assign unused_bits = ^{i_address, index_q, cur_index};

endmodule

// File: tb/tb_rggen_bus_responder.sv
// tb/tb_rggen_bus_responder.sv - randomized self-checking bench for three responders (0, 1 and 3 wait states)
module tb_rggen_bus_responder;

  localparam int NDUT = 3;
`ifdef RGGEN_BUS_RESPONDER_RANGE_CHECK_EN
  localparam bit RANGE = 1'b1;
`else
  localparam bit RANGE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [NDUT];
  logic        valid  [NDUT];
  logic        write  [NDUT];
  logic        read   [NDUT];
  logic [7:0]  addr   [NDUT];
  logic [3:0]  strobe [NDUT];
  logic [31:0] wdata  [NDUT];
  logic        ready  [NDUT];
  logic [31:0] rdata  [NDUT];
  logic [1:0]  status [NDUT];
  logic        busy   [NDUT];

  logic [31:0] mem [NDUT][16];
  int n_checks = 0;
  int n_pass   = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    rggen_bus_responder #(
      .DATA_WIDTH    (32),
      .ADDRESS_WIDTH (8),
      .WORDS         (16),
      .WAIT_CYCLES   ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n[g]),
      .i_valid      (valid[g]),
      .i_write      (write[g]),
      .i_read       (read[g]),
      .i_address    (addr[g]),
      .i_strobe     (strobe[g]),
      .i_write_data (wdata[g]),
      .o_ready      (ready[g]),
      .o_read_data  (rdata[g]),
      .o_status     (status[g]),
      .o_busy       (busy[g])
    );
  end

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at a negedge; returns at the negedge after the ready pulse has dropped.
  task automatic access(input int d, input bit wr, input bit rd, input logic [7:0] a,
                        input logic [3:0] st, input logic [31:0] wd,
                        output logic [31:0] r_o, output logic [1:0] s_o);
    int idx;
    int lat;
    bit seen;
    logic [1:0]  exp_s;
    logic [31:0] exp_d;
    bit commit;
    idx    = int'(a) / 4;
    exp_s  = 2'b00;
    exp_d  = 32'h0;
    commit = 1'b0;
    if (wr == rd) exp_s = 2'b10;
    else if (RANGE && idx >= 16) exp_s = 2'b11;
    else if (rd) exp_d = mem[d][idx % 16];
    else commit = 1'b1;
    r_o = 32'h0;
    s_o = 2'b00;
    valid[d] = 1'b1; write[d] = wr; read[d] = rd; addr[d] = a; strobe[d] = st; wdata[d] = wd;
    seen = 1'b0;
    lat  = -1;
    for (int k = 0; k <= wait_of(d) + 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        write[d] = 1'($urandom); read[d] = 1'($urandom); addr[d] = 8'($urandom);
        strobe[d] = 4'($urandom); wdata[d] = $urandom;
      end
      if (ready[d]) begin
        seen = 1'b1; lat = k; r_o = rdata[d]; s_o = status[d];
        check_eq($sformatf("busy_at_ready_d%0d", d), busy[d], 1'b1);
        break;
      end
      check_eq($sformatf("busy_wait_d%0d", d), busy[d], 1'b1);
    end
    check_eq($sformatf("ready_seen_d%0d a=%0h", d, a), seen, 1'b1);
    check_eq($sformatf("latency_d%0d", d), lat, wait_of(d));
    check_eq($sformatf("status_d%0d a=%0h", d, a), s_o, exp_s);
    check_eq($sformatf("rdata_d%0d a=%0h", d, a), r_o, exp_d);
    valid[d] = 1'b0;
    @(negedge clk);
    check_eq($sformatf("ready_pulse_d%0d", d), ready[d], 1'b0);
    check_eq($sformatf("busy_idle_d%0d", d), busy[d], 1'b0);
    check_eq($sformatf("rdata_idle_d%0d", d), rdata[d], 32'h0);
    check_eq($sformatf("status_idle_d%0d", d), status[d], 2'b00);
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (st[b]) mem[d][idx % 16][b*8 +: 8] = wd[b*8 +: 8];
      end
    end
  endtask

  logic [31:0] r;
  logic [1:0]  s;
  int          sel;

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      rst_n[d] = 1'b0; valid[d] = 1'b0; write[d] = 1'b0; read[d] = 1'b0;
      addr[d] = '0; strobe[d] = '0; wdata[d] = '0;
      for (int w = 0; w < 16; w++) mem[d][w] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check_eq($sformatf("rst_ready_d%0d", d), ready[d], 1'b0);
      check_eq($sformatf("rst_busy_d%0d", d), busy[d], 1'b0);
      check_eq($sformatf("rst_rdata_d%0d", d), rdata[d], 32'h0);
      check_eq($sformatf("rst_status_d%0d", d), status[d], 2'b00);
      rst_n[d] = 1'b1;
    end

    access(1, 1, 0, 8'h04, 4'hF, 32'hDEADBEEF, r, s);
    access(1, 0, 1, 8'h04, 4'h0, 32'h0, r, s);
    check_eq("tp_read_full", r, 32'hDEADBEEF);
    access(1, 1, 0, 8'h04, 4'h3, 32'h00001234, r, s);
    access(1, 0, 1, 8'h04, 4'h0, 32'h0, r, s);
    check_eq("tp_read_partial", r, 32'hDEAD1234);
    access(1, 0, 1, 8'h05, 4'h0, 32'h0, r, s);
    check_eq("tp_read_offset", r, 32'hDEAD1234);
    access(1, 1, 1, 8'h08, 4'hF, 32'hFFFFFFFF, r, s);
    check_eq("tp_both_status", s, 2'b10);
    access(1, 0, 0, 8'h08, 4'hF, 32'hFFFFFFFF, r, s);
    check_eq("tp_none_status", s, 2'b10);
    access(1, 0, 1, 8'h08, 4'h0, 32'h0, r, s);
    check_eq("tp_word2_unchanged", r, 32'h0);
    access(1, 1, 0, 8'h40, 4'hF, 32'hCAFEF00D, r, s);
    check_eq("tp_high_status", s, RANGE ? 2'b11 : 2'b00);
    access(1, 0, 1, 8'h00, 4'h0, 32'h0, r, s);
    check_eq("tp_word0", r, RANGE ? 32'h0 : 32'hCAFEF00D);

    // Reset lands while the three-wait responder is still waiting.
    access(2, 1, 0, 8'h14, 4'hF, 32'h11112222, r, s);
    valid[2] = 1'b1; write[2] = 1'b1; read[2] = 1'b0; addr[2] = 8'h14;
    strobe[2] = 4'hF; wdata[2] = 32'h33334444;
    @(negedge clk);
    @(negedge clk);
    check_eq("abort_no_ready_early", ready[2], 1'b0);
    rst_n[2] = 1'b0;
    @(negedge clk);
    check_eq("abort_busy_cleared", busy[2], 1'b0);
    rst_n[2] = 1'b1;
    valid[2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_eq("abort_no_ready", ready[2], 1'b0);
      @(negedge clk);
    end
    for (int w = 0; w < 16; w++) mem[2][w] = 32'h0;
    access(2, 0, 1, 8'h14, 4'h0, 32'h0, r, s);
    check_eq("abort_word_zero", r, 32'h0);

    // Back-to-back on the zero-wait responder.
    access(0, 1, 0, 8'h10, 4'hF, 32'hA5A5A5A5, r, s);
    access(0, 1, 0, 8'h14, 4'hC, 32'h5A5A5A5A, r, s);
    access(0, 0, 1, 8'h10, 4'h0, 32'h0, r, s);
    check_eq("b2b_read0", r, 32'hA5A5A5A5);
    access(0, 0, 1, 8'h14, 4'h0, 32'h0, r, s);
    check_eq("b2b_read1", r, 32'h5A5A0000);

    for (int d = 0; d < NDUT; d++) begin
      for (int t = 0; t < 25; t++) begin
        sel = $urandom_range(0, 9);
        access(d, (sel < 4) || (sel == 8), (sel >= 4 && sel < 8) || (sel == 8),
               8'($urandom), 4'($urandom), $urandom, r, s);
      end
      for (int w = 0; w < 16; w++) begin
        access(d, 0, 1, 8'(w * 4), 4'h0, 32'h0, r, s);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
